// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if -- bundle between a UART receiver/consumer pair and the
// receive FIFO.
//   master : the environment (receiver + consumer); drives the i_* signals
//   slave  : the FIFO; drives the o_* signals
// Signals
//   i_dv            byte-valid level from the receiver (rising edge = new byte)
//   i_rx_byte       received byte, stable while i_dv is high
//   i_rx_error      framing-error level from the receiver
//   i_rd_en         pop request from the consumer
//   i_clr_flags     clear overflow flag and framing-error counter
//   o_rd_data       head entry (first-word-fall-through)
//   o_empty/o_full  occupancy flags
//   o_count         occupancy 0..DEPTH
//   o_overflow      sticky: a byte was dropped
//   o_frame_err_cnt saturating framing-error event count
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);
  logic                     i_dv;
  logic [WIDTH-1:0]         i_rx_byte;
  logic                     i_rx_error;
  logic                     i_rd_en;
  logic                     i_clr_flags;
  logic [WIDTH-1:0]         o_rd_data;
  logic                     o_empty;
  logic                     o_full;
  logic [$clog2(DEPTH):0]   o_count;
  logic                     o_overflow;
  logic [7:0]               o_frame_err_cnt;

  modport master (
    output i_dv, i_rx_byte, i_rx_error, i_rd_en, i_clr_flags,
    input  o_rd_data, o_empty, o_full, o_count, o_overflow, o_frame_err_cnt
  );

  modport slave (
    input  i_dv, i_rx_byte, i_rx_error, i_rd_en, i_clr_flags,
    output o_rd_data, o_empty, o_full, o_count, o_overflow, o_frame_err_cnt
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- receive FIFO behind a UART receiver.
// Captures one byte per rising edge of i_dv, presents the head entry
// first-word-fall-through, flags dropped bytes (sticky overflow) and counts
// framing-error events (saturating at 255).
// Ports
//   i_clk  single clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    uart_rx_fifo_if slave modport (see interface header)
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  uart_rx_fifo_if.slave bus
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];

  logic          dv_prev_q,  err_prev_q;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW:0]   count_q,    count_d;
  logic          empty_q,    empty_d;
  logic          full_q,     full_d;
  logic          ovf_q,      ovf_d;
  logic [7:0]    ferr_cnt_q, ferr_cnt_d;

  logic wr_evt, err_evt, pop, push, drop;

  always_comb begin
    wr_evt  = bus.i_dv & ~dv_prev_q;
    err_evt = bus.i_rx_error & ~err_prev_q;
    pop     = bus.i_rd_en & ~empty_q;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push    = wr_evt & (~full_q | pop);
    drop    = wr_evt & full_q & ~pop;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);

    // Clear first, then let a same-cycle event re-arm the flag/counter.
    ovf_d      = bus.i_clr_flags ? 1'b0 : ovf_q;
    ferr_cnt_d = bus.i_clr_flags ? '0   : ferr_cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
    end
    if (err_evt && ferr_cnt_d != 8'hFF) begin
      ferr_cnt_d = ferr_cnt_d + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // Edge detectors start high so levels already high at release are ignored.
      dv_prev_q  <= 1'b1;
      err_prev_q <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ferr_cnt_q <= '0;
    end else begin
      dv_prev_q  <= bus.i_dv;
      err_prev_q <= bus.i_rx_error;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      ferr_cnt_q <= ferr_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.i_rx_byte;
    end
  end

  assign bus.o_rd_data       = mem[rd_ptr_q];
  assign bus.o_empty         = empty_q;
  assign bus.o_full          = full_q;
  assign bus.o_count         = count_q;
  assign bus.o_overflow      = ovf_q;
  assign bus.o_frame_err_cnt = ferr_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo -- self-checking bench for uart_rx_fifo.
// A queue-based reference model tracks FIFO contents, overflow flag and the
// framing-error counter; a vector table plus directed and random sequences
// drive the DUT through it.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  bit         m_ovf;
  int         m_ecnt;
  bit         m_dvp, m_errp;
  logic [7:0] last_head;

  typedef struct {
    bit         dv;
    logic [7:0] d;
    bit         err, rd, clr;
    int         cnt;
    bit         ovf;
    int         ecnt;
    bit         chk;
    logic [7:0] head;
  } vec_t;
  vec_t tbl[18];

  task automatic check(string name, logic [31:0] act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_ecnt = 0;
    m_dvp  = 1'b1;
    m_errp = 1'b1;
  endtask

  task automatic step(bit dv, logic [7:0] d, bit err, bit rd, bit clr);
    bit we, pop, e_evt;
    @(negedge clk);
    bus.i_dv        = dv;
    bus.i_rx_byte   = d;
    bus.i_rx_error  = err;
    bus.i_rd_en     = rd;
    bus.i_clr_flags = clr;
    #1;
    last_head = bus.o_rd_data;
    if (rd && q.size() > 0) check("head", bus.o_rd_data, q[0]);
    we    = dv && !m_dvp;
    pop   = rd && q.size() > 0;
    e_evt = err && !m_errp;
    m_dvp  = dv;
    m_errp = err;
    if (clr) begin
      m_ovf  = 1'b0;
      m_ecnt = 0;
    end
    if (pop) void'(q.pop_front());
    if (we) begin
      if (q.size() < DEPTH) q.push_back(d);
      else m_ovf = 1'b1;
    end
    if (e_evt && m_ecnt < 255) m_ecnt++;
    @(posedge clk);
    #1;
    check("count",    bus.o_count,         q.size());
    check("empty",    bus.o_empty,         int'(q.size() == 0));
    check("full",     bus.o_full,          int'(q.size() == DEPTH));
    check("overflow", bus.o_overflow,      int'(m_ovf));
    check("errcnt",   bus.o_frame_err_cnt, m_ecnt);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write(logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
    idle();
  endtask

  initial begin
    // dv, d, err, rd, clr, cnt, ovf, ecnt, chk, head
    tbl[0]  = '{1, 8'h41, 0, 0, 0, 1, 0, 0, 0, 8'h00};
    tbl[1]  = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00};
    tbl[2]  = '{1, 8'h42, 0, 0, 0, 2, 0, 0, 0, 8'h00};
    tbl[3]  = '{0, 8'h00, 0, 0, 0, 2, 0, 0, 0, 8'h00};
    tbl[4]  = '{1, 8'h43, 0, 0, 0, 3, 0, 0, 0, 8'h00};
    tbl[5]  = '{0, 8'h00, 0, 0, 0, 3, 0, 0, 0, 8'h00};
    tbl[6]  = '{0, 8'h00, 0, 1, 0, 2, 0, 0, 1, 8'h41};
    tbl[7]  = '{0, 8'h00, 0, 1, 0, 1, 0, 0, 1, 8'h42};
    tbl[8]  = '{0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 8'h43};
    tbl[9]  = '{0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 8'h00};
    tbl[10] = '{0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 8'h00};
    tbl[11] = '{0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 8'h00};
    tbl[12] = '{0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h00};
    tbl[13] = '{0, 8'h00, 1, 0, 1, 0, 0, 1, 0, 8'h00};
    tbl[14] = '{0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00};
    tbl[15] = '{1, 8'h5A, 0, 1, 0, 1, 0, 0, 0, 8'h00};
    tbl[16] = '{1, 8'h00, 0, 1, 0, 0, 0, 0, 1, 8'h5A};
    tbl[17] = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00};

    bus.i_dv = 1'b0; bus.i_rx_byte = '0; bus.i_rx_error = 1'b0;
    bus.i_rd_en = 1'b0; bus.i_clr_flags = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", bus.o_count, 0);
    check("rst_empty", bus.o_empty, 1);
    check("rst_full",  bus.o_full, 0);
    check("rst_ovf",   bus.o_overflow, 0);
    check("rst_ecnt",  bus.o_frame_err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // Vector table: basic ordering, empty pop, error edges, clear, empty+pop+write
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].dv, tbl[i].d, tbl[i].err, tbl[i].rd, tbl[i].clr);
      check("tbl_cnt",  bus.o_count, tbl[i].cnt);
      check("tbl_ovf",  bus.o_overflow, int'(tbl[i].ovf));
      check("tbl_ecnt", bus.o_frame_err_cnt, tbl[i].ecnt);
      if (tbl[i].chk) check("tbl_head", last_head, tbl[i].head);
    end

    // i_dv held high for 20 cycles: one write only
    for (int i = 0; i < 20; i++) step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    idle();
    check("dv_hold_cnt", bus.o_count, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("dv_hold_data", last_head, 8'h5A);

    // Fill, overflow, drain, clear
    for (int i = 1; i <= DEPTH; i++) write(8'(i));
    write(8'hFF);
    check("ovf_full",  bus.o_full, 1);
    check("ovf_flag",  bus.o_overflow, 1);
    check("ovf_count", bus.o_count, DEPTH);
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("drain", last_head, i);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("clr_ovf", bus.o_overflow, 0);

    // Full with simultaneous write and pop, then pointer wrap
    for (int i = 0; i < DEPTH; i++) write(8'(8'h20 + i));
    step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    check("fullrw_cnt", bus.o_count, DEPTH);
    check("fullrw_ovf", bus.o_overflow, 0);
    idle();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b0, 1'b1, 1'b0);
      idle();
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("wrap_empty", bus.o_empty, 1);

    // Framing-error saturation and clear-with-edge
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle();
    end
    check("ecnt_sat", bus.o_frame_err_cnt, 255);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("ecnt_clr_edge", bus.o_frame_err_cnt, 1);
    idle();

    // Reset mid-operation with i_dv high
    for (int i = 0; i < 5; i++) write(8'(8'h60 + i));
    check("pre_rst_cnt", bus.o_count, 5);
    @(negedge clk);
    bus.i_dv = 1'b1;
    bus.i_rx_byte = 8'h77;
    #2 rst = 1'b1;
    #1;
    check("async_rst_cnt",   bus.o_count, 0);
    check("async_rst_empty", bus.o_empty, 1);
    check("async_rst_ecnt",  bus.o_frame_err_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    check("rst_dv_held", bus.o_count, 0);
    idle();
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    check("rst_new_write", bus.o_count, 1);
    idle();

    // Random traffic: fill-biased phase, then drain-biased phase
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        step(bit'($urandom_range(0, 1)), 8'($urandom),
             bit'($urandom_range(0, 99) < 30),
             bit'($urandom_range(0, 99) < (ph == 0 ? 10 : 60)),
             bit'($urandom_range(0, 99) < 2));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; a power of two, at least 2.
REQ-002 SHALL have parameter WIDTH, default 8, data width matching the receiver byte.
REQ-003 SHALL have port i_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit, reset, asynchronous and active-high.
REQ-005 SHALL have port i_dv, input, 1 bit, byte-valid from the upstream receiver; level signal whose rising edge marks a new byte.
REQ-006 SHALL have port i_rx_byte, input, WIDTH bits, received byte, stable whenever i_dv is high.
REQ-007 SHALL have port i_rx_error, input, 1 bit, stop-bit/framing error level from the receiver.
REQ-008 SHALL have port i_rd_en, input, 1 bit, pop request from the consumer.
REQ-009 SHALL have port i_clr_flags, input, 1 bit, synchronous clear of o_overflow and o_frame_err_cnt.
REQ-010 SHALL have port o_rd_data, output, WIDTH bits, head entry, first-word-fall-through.
REQ-011 SHALL have port o_empty, output, 1 bit, high when count == 0.
REQ-012 SHALL have port o_full, output, 1 bit, high when count == DEPTH.
REQ-013 SHALL have port o_count, output, log2(DEPTH)+1 bits, current occupancy 0..DEPTH.
REQ-014 SHALL have port o_overflow, output, 1 bit, sticky flag: a byte was dropped.
REQ-015 SHALL have port o_frame_err_cnt, output, 8 bits, saturating count of framing-error events.

Function
REQ-016 SHALL register i_dv into dv_prev each cycle; a write event is i_dv=1 and dv_prev=0, once per byte however long i_dv stays high.
REQ-017 SHALL, on a write event with o_full=0 or a same-cycle accepted pop, store i_rx_byte at the write pointer and advance that pointer modulo DEPTH.
REQ-018 SHALL accept a pop only when i_rd_en=1 and o_empty=0; it advances the read pointer modulo DEPTH; i_rd_en on empty is ignored with no state change.
REQ-019 SHALL present o_rd_data = mem[rd_ptr] combinationally; o_rd_data is the byte popped by i_rd_en in that cycle; value while empty is don't-care.
REQ-020 SHALL update o_count, o_empty and o_full registered, one cycle after the event: write only +1; pop only -1; both 0.
REQ-021 SHALL, when full and a write event coincides with an accepted pop, accept both; count stays DEPTH; o_overflow unchanged.
REQ-022 SHALL, when empty and a write event coincides with i_rd_en, accept only the write; count becomes 1.
REQ-023 SHALL, on a write event while full with no accepted pop, drop the byte, leave memory, pointers and count unchanged, and set o_overflow next cycle.
REQ-024 SHALL register i_rx_error into err_prev; each rising edge increments o_frame_err_cnt, saturating at 255 with no wrap.
REQ-025 SHALL, when i_clr_flags=1, clear o_overflow and o_frame_err_cnt; a same-cycle overflow or error edge is applied after the clear, giving o_overflow=1 or o_frame_err_cnt=1.
REQ-026 SHALL NOT let i_clr_flags affect FIFO contents, pointers or count.
REQ-027 SHALL keep pointer wrap from DEPTH-1 to 0 seamless; full and empty are distinguished by o_count, not by pointer equality alone.

Reset
REQ-028 SHALL, while i_rst=1, asynchronously force pointers=0, o_count=0, o_empty=1, o_full=0, o_overflow=0, o_frame_err_cnt=0.
REQ-029 SHALL reset dv_prev=1 and err_prev=1 so a high i_dv or i_rx_error at reset release causes no event.
REQ-030 SHALL discard all stored data on reset mid-operation; memory contents need no reset.
REQ-031 SHALL resume normal operation on the first clock edge after i_rst deasserts.

Verification
REQ-032 Three i_dv pulses with bytes 0x41, 0x42, 0x43, then three i_rd_en cycles -> o_rd_data 0x41, 0x42, 0x43 in order; o_count 3->0; o_empty=1 at end.
REQ-033 i_dv held high 20 cycles with 0x5A -> exactly one write; o_count=1.
REQ-034 DEPTH=16: 16 writes, then a 17th write of 0xFF -> o_full=1, o_overflow=1, o_count=16; a drain reads bytes 1..16 with no 0xFF; i_clr_flags -> o_overflow=0.
REQ-035 Full FIFO with a write event and i_rd_en in the same cycle -> o_count stays 16, o_overflow=0; the new byte emerges last; 40 write/read cycles exercise pointer wrap with data intact.
REQ-036 300 i_rx_error rising edges -> o_frame_err_cnt=255; i_clr_flags in the same cycle as an error edge -> 1.
REQ-037 i_rst pulsed with o_count=5 while i_dv=1 -> o_count=0 and o_empty=1 immediately; no write after release until i_dv falls and rises again.
